// File: rtl/mdio_speed_poll.sv
// -----------------------------------------------------------------------------
// mdio_speed_poll
//
// Autonomous MDIO status poller. Periodically issues a clause-22 read of the
// PHY specific-status register, and from the result drives the RGMII speed
// select, the link indication and per-read completion/error pulses.
// Everything runs in the single 125 MHz clk domain; MDC is a registered,
// divided copy of clk that only toggles while a frame is in flight.
//
// Frame layout (one bit = MDC_DIV low cycles followed by MDC_DIV high cycles):
//   bits  0..31  PRE   preamble, all ones, pad driven
//   bits 32..45  CMD   ST=01, OP=10, PHY_ADDR, STAT_REG (MSB first), pad driven
//   bits 46..47  TA    turnaround, pad released, bit 47 must read 0
//   bits 48..63  DATA  register contents, MSB first, pad released
//   bit  64      GAP   idle bit, pad released
//   then one DONE cycle carrying the status_valid / read_err pulse.
//
// Ports:
//   clk           system clock (only clock)
//   rst           synchronous active-high reset
//   poll_now      one-cycle request for an immediate read
//   mdio_i        MDIO pad input
//   mdio_o        MDIO pad output value
//   mdio_t        MDIO pad tristate control, 1 = released
//   mdc_o         MDIO clock
//   speed         2'b10 = 1000M, 2'b01 = 100M, 2'b00 = 10M
//   link_up       last successfully read link bit
//   status_valid  one-cycle pulse on a clean read
//   read_err      one-cycle pulse on a failed read (no PHY or reserved speed)
//   busy          frame in flight, from frame start through DONE
// -----------------------------------------------------------------------------
module mdio_speed_poll #(
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter logic [4:0]  STAT_REG    = 5'h11,
    parameter int unsigned MDC_DIV     = 50,
    parameter int unsigned POLL_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       poll_now,
    input  logic       mdio_i,
    output logic       mdio_o,
    output logic       mdio_t,
    output logic       mdc_o,
    output logic [1:0] speed,
    output logic       link_up,
    output logic       status_valid,
    output logic       read_err,
    output logic       busy
);

    // Divider counts 0..MDC_DIV-1 within each MDC half-period.
    localparam int DIV_W = $clog2(MDC_DIV);
    localparam int TMR_W = $clog2(POLL_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_DIV - 1);
    // The timer is loaded on the frame-start edge and a new frame is launched
    // on the edge after it reads zero, so POLL_CYCLES-1 gives exactly
    // POLL_CYCLES cycles between frame starts.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(POLL_CYCLES - 1);

    // Everything the poller ever drives onto the pad, MSB is sent first.
    localparam logic [45:0] TX_FRAME = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, STAT_REG};

    // Frame bit indices at which the state changes (index of the last bit).
    localparam logic [6:0] BIT_LAST_PRE  = 7'd31;
    localparam logic [6:0] BIT_LAST_CMD  = 7'd45;
    localparam logic [6:0] BIT_TA2       = 7'd47;
    localparam logic [6:0] BIT_LAST_DATA = 7'd63;
    localparam logic [6:0] BIT_LAST_GAP  = 7'd64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_CMD,
        S_TA,
        S_DATA,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q,        state_d;
    logic [DIV_W-1:0]  div_cnt_q,      div_cnt_d;
    logic [6:0]        bit_cnt_q,      bit_cnt_d;
    logic              mdc_q,          mdc_d;
    logic [45:0]       tx_sr_q,        tx_sr_d;
    logic              mdio_t_q,       mdio_t_d;
    logic [15:0]       rx_sr_q,        rx_sr_d;
    logic              ta_err_q,       ta_err_d;
    logic [1:0]        speed_q,        speed_d;
    logic              link_up_q,      link_up_d;
    logic              status_valid_q, status_valid_d;
    logic              read_err_q,     read_err_d;
    logic              pending_q,      pending_d;
    logic [TMR_W-1:0]  timer_q,        timer_d;

    logic timer_expired;
    logic request;
    logic phase_end;
    logic start_frame;

    assign timer_expired = (timer_q == '0);
    // Requests seen while idle (or in DONE) launch a frame; the same requests
    // seen mid-frame collapse into the single pending flag.
    assign request       = timer_expired | poll_now | pending_q;
    assign phase_end     = (div_cnt_q == DIV_LAST);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal gets a default before the case so that no path
        // through this block leaves a value unassigned and infers a latch.
        state_d        = state_q;
        div_cnt_d      = div_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        mdc_d          = mdc_q;
        tx_sr_d        = tx_sr_q;
        mdio_t_d       = mdio_t_q;
        rx_sr_d        = rx_sr_q;
        ta_err_d       = ta_err_q;
        speed_d        = speed_q;
        link_up_d      = link_up_q;
        status_valid_d = 1'b0;
        read_err_d     = 1'b0;
        pending_d      = pending_q;
        timer_d        = timer_expired ? timer_q : timer_q - TMR_W'(1);
        start_frame    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                start_frame = request;
            end

            S_DONE: begin
                // A request that arrived during the frame starts the next frame
                // directly, without passing through IDLE.
                state_d     = S_IDLE;
                start_frame = request;
            end

            S_PRE, S_CMD, S_TA, S_DATA, S_GAP: begin
                if (timer_expired || poll_now) begin
                    pending_d = 1'b1;
                end

                if (!phase_end) begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end else begin
                    div_cnt_d = '0;
                    if (!mdc_q) begin
                        // End of low phase: MDC rises, input is sampled here.
                        mdc_d = 1'b1;
                        if (bit_cnt_q == BIT_TA2) begin
                            ta_err_d = mdio_i;
                        end
                        if (state_q == S_DATA) begin
                            rx_sr_d = {rx_sr_q[14:0], mdio_i};
                        end
                    end else begin
                        // End of high phase: MDC falls and the next bit is
                        // presented on the pad in the same edge.
                        mdc_d     = 1'b0;
                        bit_cnt_d = bit_cnt_q + 7'd1;
                        tx_sr_d   = {tx_sr_q[44:0], 1'b1};
                        if (bit_cnt_q == BIT_LAST_CMD) begin
                            mdio_t_d = 1'b1;
                        end

                        if (bit_cnt_q == BIT_LAST_PRE) begin
                            state_d = S_CMD;
                        end else if (bit_cnt_q == BIT_LAST_CMD) begin
                            state_d = S_TA;
                        end else if (bit_cnt_q == BIT_TA2) begin
                            state_d = S_DATA;
                        end else if (bit_cnt_q == BIT_LAST_DATA) begin
                            state_d = S_GAP;
                        end else if (bit_cnt_q == BIT_LAST_GAP) begin
                            state_d = S_DONE;
                            // Results land on the edge entering DONE so the
                            // pulse and the new speed/link appear together.
                            if (ta_err_q || rx_sr_q[15:14] == 2'b11) begin
                                read_err_d = 1'b1;
                            end else begin
                                status_valid_d = 1'b1;
                                link_up_d      = rx_sr_q[10];
                                // On link down the last negotiated speed is kept.
                                if (rx_sr_q[10]) begin
                                    speed_d = rx_sr_q[15:14];
                                end
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_frame) begin
            state_d   = S_PRE;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            mdc_d     = 1'b0;
            tx_sr_d   = TX_FRAME;
            mdio_t_d  = 1'b0;
            ta_err_d  = 1'b0;
            pending_d = 1'b0;
            timer_d   = TMR_LOAD;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register load from values
        // that existed before the edge, independent of statement order.
        if (rst) begin
            state_q        <= S_IDLE;
            div_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            mdc_q          <= 1'b0;
            tx_sr_q        <= '1;
            mdio_t_q       <= 1'b1;
            rx_sr_q        <= '0;
            ta_err_q       <= 1'b0;
            speed_q        <= 2'b10;
            link_up_q      <= 1'b0;
            status_valid_q <= 1'b0;
            read_err_q     <= 1'b0;
            pending_q      <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            mdc_q          <= mdc_d;
            tx_sr_q        <= tx_sr_d;
            mdio_t_q       <= mdio_t_d;
            rx_sr_q        <= rx_sr_d;
            ta_err_q       <= ta_err_d;
            speed_q        <= speed_d;
            link_up_q      <= link_up_d;
            status_valid_q <= status_valid_d;
            read_err_q     <= read_err_d;
            pending_q      <= pending_d;
            timer_q        <= timer_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all come straight from registers)
    // -------------------------------------------------------------------------
    assign mdio_o       = tx_sr_q[45];
    assign mdio_t       = mdio_t_q;
    assign mdc_o        = mdc_q;
    assign speed        = speed_q;
    assign link_up      = link_up_q;
    assign status_valid = status_valid_q;
    assign read_err     = read_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/mdio_speed_poll.md
# mdio_speed_poll

Autonomous MDIO status poller that periodically reads the PHY's specific-status register and drives the `speed` input of `rgmii_phy_if`. It sits between the board-level MDIO pad (`TRELLIS_IO` bidir buffer) and the RGMII interface, in the 125 MHz `clk` domain. It replaces manual speed selection with link-state-driven selection, and reports link state and read errors.

## Interface
- `PHY_ADDR`, 5'd0: PHY address placed in every read frame.
- `STAT_REG`, 5'h11: register read each poll. Layout: speed code in [15:14], link bit in [10].
- `MDC_DIV`, 50: `clk` cycles per MDC half-period. Minimum 2. Default gives 1.25 MHz at 125 MHz.
- `POLL_CYCLES`, 12_500_000: `clk` cycles between successive frame starts.

- `clk`  in  1  system clock, 125 MHz. The only clock.
- `rst`  in  1  synchronous, active-high reset.
- `poll_now`  in  1  one-cycle request for an immediate read.
- `mdio_i`  in  1  MDIO pad input.
- `mdio_o`  out  1  MDIO pad output value.
- `mdio_t`  out  1  pad tristate; 1 = released.
- `mdc_o`  out  1  MDIO clock.
- `speed`  out  2  2'b10 = 1000M, 2'b01 = 100M, 2'b00 = 10M.
- `link_up`  out  1  last successfully read link bit.
- `status_valid`  out  1  one-cycle pulse when a read completed cleanly.
- `read_err`  out  1  one-cycle pulse when a read failed.
- `busy`  out  1  frame or post-frame idle gap in progress.

## Operation
- Reset values:
  - `speed` = 2'b10
  - `link_up` = 0
  - `mdc_o` = 0, `mdio_o` = 1, `mdio_t` = 1
  - `status_valid` = 0, `read_err` = 0, `busy` = 0
  - internal pending flag = 0
  - poll timer = 0
- States: IDLE → PRE (32 bits) → CMD (14 bits) → TA (2 bits) → DATA (16 bits) → GAP (1 bit) → DONE (1 cycle) → IDLE.
- CMD bits are sent MSB first:
  - ST = 01
  - OP = 10 (read)
  - PHY_ADDR[4:0]
  - STAT_REG[4:0]
- PRE and CMD drive the pad: `mdio_t` = 0. PRE sends `mdio_o` = 1.
- TA, DATA and GAP release the pad: `mdio_t` = 1, `mdio_o` = 1.
- TA bit 2 is sampled. If it is 1, no PHY responded and the read is marked as failed.
- DATA is shifted in MSB first.
- DONE, clean read:
  - Speed code 11 is reserved: pulse `read_err`; `speed` and `link_up` are unchanged.
  - Otherwise set `link_up` = data[10] and pulse `status_valid`.
  - Update `speed` = data[15:14] only if data[10] = 1. On link down, `speed` holds its last value.
- DONE, failed read (TA bit 2 = 1): pulse `read_err`; `speed` and `link_up` are unchanged.
- Frame start conditions, checked in IDLE:
  - poll timer expired, or
  - `poll_now` asserted, or
  - pending flag set.
- The first frame starts in the cycle after `rst` deasserts. The timer then reloads at every frame start.
- `poll_now` or timer expiry while `busy` sets the pending flag; requests merge into one frame. The pending frame starts the cycle after DONE.
- `busy` = 1 from the frame-start cycle through DONE inclusive.
- Reset mid-frame: all outputs return to reset values on the next edge and the frame is abandoned. The first post-reset frame then starts as above.

## Timing
- One MDIO bit = 2×MDC_DIV cycles: a low phase of MDC_DIV cycles, then a high phase of MDC_DIV cycles. `mdc_o` is registered.
- Bit k's `mdio_o`/`mdio_t` values change on the same edge where `mdc_o` goes 1→0 (or the frame-start edge for bit 0). They are stable through that bit's high phase.
- `mdio_i` sampling: at the edge where `mdc_o` is set 0→1, take the value present in that cycle. This is the last cycle of the low phase.
- Frame plus gap = 65 bits = 130×MDC_DIV cycles.
- DONE occurs at frame start + 130×MDC_DIV. That cycle is the `status_valid`/`read_err` pulse, and `speed`/`link_up` update on the same edge.
- Poll interval = max(POLL_CYCLES, 130×MDC_DIV + 1) cycles between frame starts.
- Timer width = $clog2(POLL_CYCLES+1).
- MDC divider counts 0..MDC_DIV-1 and is cleared at frame start.
- `mdc_o` stays 0 while IDLE.

## Test plan
- **Bit-level frame check.** MDC_DIV=2, PHY_ADDR=1, PHY model returns 0xAC00. Capture `mdio_o` at rising MDC: 32 ones, then 0110, 00001, 10001. `mdio_t` = 1 from bit 46. Expect `status_valid` at cycle 260 after reset release, `speed` = 10, `link_up` = 1.
- **Link-down hold.** Return 0x4400, then 0x0000. First read: `speed` = 01, `link_up` = 1. Second read: `speed` stays 01, `link_up` = 0, `status_valid` pulses both times.
- **No PHY.** `mdio_i` held 1. `read_err` pulses; `speed` = 10 and `link_up` = 0 unchanged; `status_valid` never asserts.
- **Reserved speed code.** Return 0xC400. `read_err` pulses; `speed` and `link_up` are unchanged.
- **Request merging.** Pulse `poll_now` twice mid-frame, POLL_CYCLES=1000. Exactly one extra frame starts the cycle after DONE. The next frame start is 1000 cycles later.
- **Reset mid-frame.** Assert `rst` during DATA bit 5. Next edge: `mdio_t` = 1, `mdc_o` = 0, `busy` = 0, `speed` = 10. A fresh frame starts the cycle after `rst` drops.
